// File: rtl/sn74hc595_rx.sv
// Receiver for a WIDTH-bit SN74HC595 chain: oversamples SER/SRCLK/RCLK in the clk domain,
// rebuilds the storage register and flags frames whose length differs from WIDTH.
module sn74hc595_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sr_data,
  input  logic             sr_clk,
  input  logic             sr_latch,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             frame_err,
  output logic             qh_out,
  output logic [7:0]       bit_count
);

  localparam logic [7:0] WIDTH_COUNT = 8'(WIDTH);

  logic [SYNC_STAGES-1:0] data_sync, clk_sync, latch_sync, fill;
  logic                   data_s, clk_s, latch_s, filled;
  logic                   clk_prev, clk_arm, latch_prev, latch_arm;
  logic                   shift_ev, latch_ev;
  logic [WIDTH-1:0]       shift_reg;

  // NOTE: every flop here is cleared by rst, including the data registers, so a partial
  // frame never survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sync  <= '0;
      clk_sync   <= '0;
      latch_sync <= '0;
      fill       <= '0;
    end else begin
      data_sync  <= {data_sync[SYNC_STAGES-2:0], sr_data};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], sr_clk};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], sr_latch};
      fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign data_s  = data_sync[SYNC_STAGES-1];
  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign latch_s = latch_sync[SYNC_STAGES-1];
  // The reset zeros in the synchronizers are not real line samples; arming waits until
  // they have been flushed, so a line held high through reset cannot look like an edge.
  assign filled  = fill[SYNC_STAGES-1];

  assign shift_ev = clk_arm & ~clk_prev & clk_s;
  assign latch_ev = latch_arm & ~latch_prev & latch_s;

  // NOTE: sequential state uses non-blocking assignments so every register sees the
  // pre-edge values of the others (the latch captures the pre-shift shift_reg).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev   <= 1'b0;
      clk_arm    <= 1'b0;
      latch_prev <= 1'b0;
      latch_arm  <= 1'b0;
    end else begin
      clk_prev   <= clk_s;
      latch_prev <= latch_s;
      clk_arm    <= clk_arm | (filled & ~clk_s);
      latch_arm  <= latch_arm | (filled & ~latch_s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      bit_count <= '0;
    end else begin
      q_valid <= latch_ev;
      if (shift_ev) shift_reg <= {shift_reg[WIDTH-2:0], data_s};
      if (latch_ev) begin
        q         <= shift_reg;
        frame_err <= (bit_count != WIDTH_COUNT);
        bit_count <= shift_ev ? 8'd1 : 8'd0;
      end else if (shift_ev && bit_count != 8'hFF) begin
        bit_count <= bit_count + 8'd1;
      end
    end
  end

  assign qh_out = shift_reg[WIDTH-1];

endmodule

// File: tb/tb_sn74hc595_rx.sv
// Directed bench for sn74hc595_rx: table of frames plus hand-written sequences for reset,
// tied SRCLK/RCLK, lines held high through reset and repeated latches.
module tb_sn74hc595_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sr_data = 1'b0;
  logic        sr_clk = 1'b0;
  logic        sr_latch = 1'b0;
  logic [15:0] q;
  logic        q_valid, frame_err, qh_out;
  logic [7:0]  bit_count;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int doubles = 0;
  logic prev_qv = 1'b0;

  sn74hc595_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch),
    .q(q), .q_valid(q_valid), .frame_err(frame_err), .qh_out(qh_out), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q_valid) pulses++;
    if (q_valid && prev_qv) doubles++;
    prev_qv = q_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    @(negedge clk);
    sr_data = b;
    repeat (4) @(negedge clk);
    sr_clk = 1'b1;
    repeat (4) @(negedge clk);
    sr_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(data[i]);
  endtask

  // Raise RCLK (and SRCLK too when tied), find the q_valid pulse within a bounded window.
  task automatic do_latch(input logic tied, output int lat, output logic [15:0] got_q,
                          output logic got_err, output logic [7:0] got_cnt);
    lat = -1; got_q = 'x; got_err = 1'bx; got_cnt = 'x;
    @(negedge clk);
    sr_latch = 1'b1;
    if (tied) sr_clk = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (q_valid) begin
        lat = c; got_q = q; got_err = frame_err; got_cnt = bit_count;
        break;
      end
    end
    @(negedge clk);
    check("q_valid_one_cycle", 32'(q_valid), 32'd0);
    repeat (2) @(negedge clk);
    sr_latch = 1'b0;
    if (tied) sr_clk = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic [15:0] exp_q;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          lat;
    logic [15:0] gq;
    logic        ge;
    logic [7:0]  gc;
    int          p0;
    logic [15:0] model;

    vecs[0] = '{32'h0000A55A, 16, 16'hA55A, 1'b0};
    vecs[1] = '{32'h00007FFF, 15, 16'h7FFF, 1'b1};  // A55A's LSB (0) ends up on top
    vecs[2] = '{32'h00001234, 16, 16'h1234, 1'b0};
    vecs[3] = '{32'h00010F0F, 17, 16'h0F0F, 1'b1};  // over-length: leading 1 falls out
    vecs[4] = '{32'h00000000, 0,  16'h0F0F, 1'b1};  // latch with no shifts
    vecs[5] = '{32'h0000C3C3, 16, 16'hC3C3, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_q_valid", 32'(q_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_qh_out", 32'(qh_out), 32'd0);
    check("rst_bit_count", 32'(bit_count), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      send(vecs[v].data, vecs[v].nbits);
      check($sformatf("v%0d_count_pre", v), 32'(bit_count), 32'(vecs[v].nbits));
      do_latch(1'b0, lat, gq, ge, gc);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd3);
      check($sformatf("v%0d_q", v), 32'(gq), 32'(vecs[v].exp_q));
      check($sformatf("v%0d_err", v), 32'(ge), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_count_post", v), 32'(gc), 32'd0);
    end
    check("qh_out_after_c3c3", 32'(qh_out), 32'd1);

    // Reset in the middle of a frame
    send(32'h000000FF, 8);
    check("mid_count", 32'(bit_count), 32'd8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q", 32'(q), 32'd0);
    check("mid_rst_count", 32'(bit_count), 32'd0);
    check("mid_rst_qh", 32'(qh_out), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_q_held", 32'(q), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(32'h000000FF, 16);
    do_latch(1'b0, lat, gq, ge, gc);
    check("post_rst_q", 32'(gq), 32'h00FF);
    check("post_rst_err", 32'(ge), 32'd0);

    // Two latches with no shifts in between
    send(32'h0000BEEF, 16);
    do_latch(1'b0, lat, gq, ge, gc);
    check("beef1_q", 32'(gq), 32'hBEEF);
    check("beef1_err", 32'(ge), 32'd0);
    do_latch(1'b0, lat, gq, ge, gc);
    check("beef2_lat", 32'(lat), 32'd3);
    check("beef2_q", 32'(gq), 32'hBEEF);
    check("beef2_err", 32'(ge), 32'd1);

    // Lines held high across reset release
    @(negedge clk);
    sr_clk = 1'b1;
    sr_latch = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    repeat (20) @(negedge clk);
    check("hold_no_pulse", 32'(pulses - p0), 32'd0);
    check("hold_no_shift", 32'(bit_count), 32'd0);
    sr_clk = 1'b0;
    sr_latch = 1'b0;
    repeat (6) @(negedge clk);
    sr_clk = 1'b1;
    repeat (6) @(negedge clk);
    check("hold_shift_after_rearm", 32'(bit_count), 32'd1);
    check("hold_still_no_pulse", 32'(pulses - p0), 32'd0);
    sr_clk = 1'b0;
    repeat (5) @(negedge clk);
    do_latch(1'b0, lat, gq, ge, gc);
    check("hold_latch_lat", 32'(lat), 32'd3);
    check("hold_latch_err", 32'(ge), 32'd1);

    // Tied SRCLK/RCLK: each latch shows the state before its own shift
    reset_cycle();
    sr_data = 1'b1;
    model = 16'h0000;
    for (int k = 1; k <= 17; k++) begin
      do_latch(1'b1, lat, gq, ge, gc);
      check($sformatf("tied%0d_q", k), 32'(gq), 32'(model));
      check($sformatf("tied%0d_err", k), 32'(ge), 32'd1);
      model = {model[14:0], 1'b1};
    end
    check("tied_final_q", 32'(q), 32'hFFFF);
    check("tied_final_count", 32'(bit_count), 32'd1);

    check("no_back_to_back_valid", 32'(doubles), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
